// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: issues synchronous memory reads for in-range PCs and
// returns instructions in order through a 2-entry response FIFO with flush support.
module inst_fetch_responder #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [31:0]       resp_addr,
  output logic              resp_err
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      r_fifo [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        r_inflight;
  logic [31:0] r_if_addr;
  logic        r_if_err;

  logic        w_head_live;
  logic        w_pop;
  logic        w_push;
  logic        w_accept;
  logic        w_oor;
  logic [2:0]  w_occ;
  entry_t      w_head;
  entry_t      w_push_entry;

  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_head_live = (r_count != 2'd0) && !rst;
  assign w_head      = r_fifo[r_rd_ptr];

  assign resp_valid  = w_head_live && !flush;
  assign w_pop       = resp_valid && resp_ready;
  assign resp_inst   = w_head_live ? w_head.inst : 32'h0;
  assign resp_addr   = w_head_live ? w_head.addr : 32'h0;
  assign resp_err    = w_head_live ? w_head.err  : 1'b0;

  // A full slot may be reused in the same cycle the head is popped.
  assign req_ready   = !rst && !flush && ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
  assign w_accept    = req_valid && req_ready;
  assign w_oor       = |req_addr[31:ADDR_W];
  assign mem_en      = w_accept && !w_oor;
  assign mem_addr    = req_addr[ADDR_W-1:0];

  assign w_push               = r_inflight && !rst && !flush;
  assign w_push_entry.inst    = r_if_err ? NOP_INST : mem_rdata;
  assign w_push_entry.addr    = r_if_addr;
  assign w_push_entry.err     = r_if_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; it is only observable while r_count says
  // the entry is valid, so clearing it would cost logic for no behavioural gain.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_if_addr <= req_addr;
      r_if_err  <= w_oor;
    end
    if (w_push) r_fifo[r_wr_ptr] <= w_push_entry;
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed self-checking bench for inst_fetch_responder with a synchronous memory model.
module tb_inst_fetch_responder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  logic              flush;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_inst;
  logic [31:0]       resp_addr;
  logic              resp_err;

  logic [31:0] mem [2**ADDR_W];
  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_responder #(.ADDR_W(ADDR_W), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_addr(resp_addr), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  function automatic logic [31:0] memval(input int i);
    if (i == 5) return 32'h2002_0001;
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = memval(i);
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; resp_ready = 1'b0;

    // Reset behaviour
    tick(); #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_inst", resp_inst, 0);
    tick(); rst = 1'b0; #1;
    check("rel_req_ready", req_ready, 1);
    check("rel_resp_valid", resp_valid, 0);

    // Single fetch of address 5
    req_valid = 1'b1; req_addr = 32'h5; #1;
    check("single_mem_en", mem_en, 1);
    check("single_mem_addr", 32'(mem_addr), 32'h5);
    tick(); req_valid = 1'b0; #1;
    check("single_n1_valid", resp_valid, 0);
    tick(); #1;
    check("single_valid", resp_valid, 1);
    check("single_inst", resp_inst, 32'h2002_0001);
    check("single_addr", resp_addr, 32'h5);
    check("single_err", resp_err, 0);
    tick(); #1;
    check("hold_valid", resp_valid, 1);
    check("hold_inst", resp_inst, 32'h2002_0001);
    resp_ready = 1'b1;
    tick(); resp_ready = 1'b0; #1;
    check("single_pop_valid", resp_valid, 0);
    check("single_pop_inst", resp_inst, 0);

    // Streaming addresses 0..7 with resp_ready held high
    resp_ready = 1'b1; k = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8); req_addr = 32'(c); #1;
      if (c < 8) check("stream_ready", req_ready, 1);
      check("stream_valid", resp_valid, ((c >= 2) && (c < 10)) ? 1 : 0);
      if (resp_valid) begin
        check("stream_addr", resp_addr, 32'(k));
        check("stream_inst", resp_inst, memval(k));
        k++;
      end
      tick();
    end
    check("stream_count", 32'(k), 8);
    req_valid = 1'b0; resp_ready = 1'b0;

    // Backpressure: two accepted, third waits for the first pop
    req_valid = 1'b1; req_addr = 32'h10; #1;
    check("bp_a_ready", req_ready, 1);
    tick(); req_addr = 32'h11; #1;
    check("bp_b_ready", req_ready, 1);
    tick(); req_addr = 32'h12; #1;
    check("bp_c_ready", req_ready, 0);
    tick(); #1;
    check("bp_d_ready", req_ready, 0);
    check("bp_d_head", resp_addr, 32'h10);
    resp_ready = 1'b1; #1;
    check("bp_pop_ready", req_ready, 1);
    check("bp_pop_mem_en", mem_en, 1);
    check("bp_pop_mem_addr", 32'(mem_addr), 32'h12);
    tick(); req_valid = 1'b0; #1;
    check("bp_e_valid", resp_valid, 1);
    check("bp_e_addr", resp_addr, 32'h11);
    tick(); #1;
    check("bp_f_valid", resp_valid, 1);
    check("bp_f_addr", resp_addr, 32'h12);
    check("bp_f_inst", resp_inst, 32'hA000_0012);
    tick(); #1;
    check("bp_g_valid", resp_valid, 0);
    resp_ready = 1'b0;

    // Flush with one queued and one in flight
    req_valid = 1'b1; req_addr = 32'h20; #1;
    tick(); req_addr = 32'h21; #1;
    check("fl_b_ready", req_ready, 1);
    tick(); req_addr = 32'h22; flush = 1'b1; #1;
    check("fl_valid", resp_valid, 0);
    check("fl_ready", req_ready, 0);
    check("fl_mem_en", mem_en, 0);
    tick(); flush = 1'b0; req_addr = 32'h40; #1;
    check("fl_next_valid", resp_valid, 0);
    check("fl_next_ready", req_ready, 1);
    tick(); req_valid = 1'b0; #1;
    check("fl_stale_valid", resp_valid, 0);
    tick(); #1;
    check("fl_new_valid", resp_valid, 1);
    check("fl_new_addr", resp_addr, 32'h40);
    check("fl_new_inst", resp_inst, 32'hA000_0040);
    resp_ready = 1'b1;
    tick(); resp_ready = 1'b0; #1;
    check("fl_drain_valid", resp_valid, 0);

    // Consecutive flushes while empty
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h50; #1;
    check("fl2_a_ready", req_ready, 0);
    check("fl2_a_mem_en", mem_en, 0);
    tick(); #1;
    check("fl2_b_ready", req_ready, 0);
    tick(); flush = 1'b0; req_valid = 1'b0; #1;
    check("fl2_after_ready", req_ready, 1);
    check("fl2_after_valid", resp_valid, 0);

    // Out-of-range fetch
    req_valid = 1'b1; req_addr = 32'h100; #1;
    check("oor_ready", req_ready, 1);
    check("oor_mem_en", mem_en, 0);
    tick(); req_valid = 1'b0; #1;
    tick(); #1;
    check("oor_valid", resp_valid, 1);
    check("oor_err", resp_err, 1);
    check("oor_inst", resp_inst, 32'h0);
    check("oor_addr", resp_addr, 32'h100);
    resp_ready = 1'b1;
    tick(); resp_ready = 1'b0; #1;
    check("oor_pop_valid", resp_valid, 0);

    // Reset with one queued and one in flight
    req_valid = 1'b1; req_addr = 32'h30; #1;
    tick(); req_addr = 32'h31; #1;
    tick(); req_valid = 1'b0; rst = 1'b1; #1;
    check("mrst_valid", resp_valid, 0);
    check("mrst_ready", req_ready, 0);
    check("mrst_inst", resp_inst, 0);
    check("mrst_mem_en", mem_en, 0);
    tick(); rst = 1'b0; #1;
    check("mrst_rel_valid", resp_valid, 0);
    check("mrst_rel_ready", req_ready, 1);
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      check("mrst_no_stale", resp_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
